// File: rtl/adc_avg_peak_pkg.sv
// Shared constants and helpers for the ADC averaging / peak-hold stage.
// Imported by the interface, the per-channel statistics block and the top.
package adc_avg_peak_pkg;

    localparam int C_ADC_BITS             = 12;
    localparam int C_ADC_CHANNELS         = 4;
    localparam int C_ADC_AVG_LOG2_DEFAULT = 4;

    typedef logic [C_ADC_BITS-1:0] adc_sample_t;

    // Sample counter needs at least one bit even when every sample ends a block.
    function automatic int cnt_width(input int avg_log2);
        return (avg_log2 > 0) ? avg_log2 : 1;
    endfunction

endpackage

// File: rtl/adc_avg_peak_if.sv
// Sample-in / statistics-out bundle between the ADC reader side and the display side.
interface adc_avg_peak_if
    import adc_avg_peak_pkg::*;
#(
    parameter int C_channels = C_ADC_CHANNELS,
    parameter int C_bits     = C_ADC_BITS
);
    logic                         clken;
    logic                         dv;
    logic [C_channels*C_bits-1:0] data;
    logic                         clear_peak;
    logic [C_channels*C_bits-1:0] avg;
    logic                         avg_dv;
    logic [C_channels*C_bits-1:0] peak_min;
    logic [C_channels*C_bits-1:0] peak_max;
    logic                         peak_valid;

    modport master (
        output clken, dv, data, clear_peak,
        input  avg, avg_dv, peak_min, peak_max, peak_valid
    );

    modport slave (
        input  clken, dv, data, clear_peak,
        output avg, avg_dv, peak_min, peak_max, peak_valid
    );
endinterface

// File: rtl/adc_avg_peak_chan_stat.sv
// One channel: block accumulator with truncating average, plus min/max peak hold.
// Accept / block-end / clear strobes come from the parent's shared counter.
module adc_chan_stat
    import adc_avg_peak_pkg::*;
#(
    parameter int C_bits     = C_ADC_BITS,
    parameter int C_avg_log2 = C_ADC_AVG_LOG2_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept_i,
    input  logic              block_end_i,
    input  logic              clear_i,
    input  logic [C_bits-1:0] sample_i,
    output logic [C_bits-1:0] avg_o,
    output logic [C_bits-1:0] min_o,
    output logic [C_bits-1:0] max_o
);
    localparam int AW = C_bits + C_avg_log2;

    logic [AW-1:0]     acc_q, acc_d, sum_s;
    logic [C_bits-1:0] avg_q, avg_d;
    logic [C_bits-1:0] min_q, min_d;
    logic [C_bits-1:0] max_q, max_d;

    // Next-state for accumulator, average and peaks.
    always_comb begin
        sum_s = acc_q + AW'(sample_i);
        acc_d = acc_q;
        avg_d = avg_q;
        min_d = min_q;
        max_d = max_q;
        if (block_end_i) begin
            acc_d = {AW{1'b0}};
            avg_d = C_bits'(sum_s >> C_avg_log2);
        end else if (accept_i) begin
            acc_d = sum_s;
        end else begin
            acc_d = acc_q;
        end
        // A clear coinciding with a sample lets that sample seed both registers.
        if (accept_i && clear_i) begin
            min_d = sample_i;
            max_d = sample_i;
        end else if (accept_i) begin
            min_d = (sample_i < min_q) ? sample_i : min_q;
            max_d = (sample_i > max_q) ? sample_i : max_q;
        end else if (clear_i) begin
            min_d = {C_bits{1'b1}};
            max_d = {C_bits{1'b0}};
        end else begin
            min_d = min_q;
            max_d = max_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= {AW{1'b0}};
            avg_q <= {C_bits{1'b0}};
            min_q <= {C_bits{1'b1}};
            max_q <= {C_bits{1'b0}};
        end else begin
            acc_q <= acc_d;
            avg_q <= avg_d;
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign avg_o = avg_q;
    assign min_o = min_q;
    assign max_o = max_q;
endmodule

// File: rtl/adc_avg_peak.sv
// Per-channel block averaging and min/max peak hold for the on-screen ADC readout.
// Owns the shared sample counter, avg_dv and peak_valid; channels are replicated.
module adc_avg_peak
    import adc_avg_peak_pkg::*;
#(
    parameter int C_channels = C_ADC_CHANNELS,
    parameter int C_bits     = C_ADC_BITS,
    parameter int C_avg_log2 = C_ADC_AVG_LOG2_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    adc_avg_peak_if.slave  bus
);
    localparam int             CW       = cnt_width(C_avg_log2);
    localparam logic [CW-1:0]  CNT_LAST = CW'((1 << C_avg_log2) - 1);
    localparam int             W        = C_channels * C_bits;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          avg_dv_q;
    logic          peak_valid_q, peak_valid_d;
    logic          accept_s, clear_s, block_end_s;
    logic [W-1:0]  avg_s, min_s, max_s;

    // Strobe decode and counter / valid next-state.
    always_comb begin
        accept_s     = bus.dv & bus.clken;
        clear_s      = bus.clear_peak & bus.clken;
        block_end_s  = accept_s && (cnt_q == CNT_LAST);
        cnt_d        = cnt_q;
        peak_valid_d = peak_valid_q;
        if (block_end_s) begin
            cnt_d = {CW{1'b0}};
        end else if (accept_s) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (accept_s) begin
            peak_valid_d = 1'b1;
        end else if (clear_s) begin
            peak_valid_d = 1'b0;
        end else begin
            peak_valid_d = peak_valid_q;
        end
    end

    // Shared control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= {CW{1'b0}};
            avg_dv_q     <= 1'b0;
            peak_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            avg_dv_q     <= block_end_s;
            peak_valid_q <= peak_valid_d;
        end
    end

    for (genvar ch = 0; ch < C_channels; ch++) begin : g_chan
        adc_chan_stat #(
            .C_bits     (C_bits),
            .C_avg_log2 (C_avg_log2)
        ) u_stat (
            .clk         (clk),
            .rst_n       (rst_n),
            .accept_i    (accept_s),
            .block_end_i (block_end_s),
            .clear_i     (clear_s),
            .sample_i    (bus.data[ch*C_bits +: C_bits]),
            .avg_o       (avg_s[ch*C_bits +: C_bits]),
            .min_o       (min_s[ch*C_bits +: C_bits]),
            .max_o       (max_s[ch*C_bits +: C_bits])
        );
    end

    assign bus.avg        = avg_s;
    assign bus.avg_dv     = avg_dv_q;
    assign bus.peak_min   = min_s;
    assign bus.peak_max   = max_s;
    assign bus.peak_valid = peak_valid_q;
endmodule
